// File: rtl/iact_csc_encoder_if.sv
// Stream bundle between the ReLU stage, the CSC encoder and the iact SRAM writer.
// Handshake: every channel uses valid/ready. A transfer happens on a rising
// clock edge where both valid and ready are high. Once raised, valid and its
// payload stay stable until that transfer; ready may change freely and never
// depends combinationally on the same channel's valid.
interface iact_csc_encoder_if #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 4,
  parameter int ADDR_W = 7
);
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [DATA_W-1:0] csc_data;
  logic [ROW_W-1:0]  csc_count;
  logic              csc_valid;
  logic              csc_ready;
  logic [ADDR_W-1:0] csc_addr;
  logic              csc_addr_valid;
  logic              csc_addr_ready;

  // Activation source and CSC sink side.
  modport master (
    output data_in, data_in_valid, csc_ready, csc_addr_ready,
    input  data_in_ready, csc_data, csc_count, csc_valid, csc_addr, csc_addr_valid
  );

  // Encoder side.
  modport slave (
    input  data_in, data_in_valid, csc_ready, csc_addr_ready,
    output data_in_ready, csc_data, csc_count, csc_valid, csc_addr, csc_addr_valid
  );
endinterface

// File: rtl/iact_csc_encoder.sv
// Compresses rectified activation columns into CSC form: one (data, row) pair
// per nonzero element and one cumulative nonzero address per column end.
module iact_csc_encoder #(
  parameter int DATA_W  = 8,
  parameter int COL_LEN = 16,
  parameter int ROW_W   = 4,
  parameter int ADDR_W  = 7,
  parameter int COLS_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [COLS_W-1:0]    cfg_num_cols,
  iact_csc_encoder_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [1:0]           o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(COL_LEN - 1);

  logic [1:0]        r_state;
  logic [COLS_W-1:0] r_num_cols;
  logic [COLS_W-1:0] r_col_cnt;
  logic [ROW_W-1:0]  r_row_cnt;
  logic [ADDR_W-1:0] r_nz_cnt;
  logic              r_overflow;
  logic              r_done;
  logic [DATA_W-1:0] r_csc_data;
  logic [ROW_W-1:0]  r_csc_count;
  logic              r_csc_valid;
  logic [ADDR_W-1:0] r_csc_addr;
  logic              r_addr_valid;

  logic              w_ready;
  logic              w_accept;
  logic              w_nz;
  logic              w_last_row;
  logic              w_last_col;
  logic [ADDR_W-1:0] w_nz_next;

  // Input is taken only while running and when neither output slot would be
  // overwritten before the sink has consumed it.
  assign w_ready    = (r_state == S_RUN) &&
                      (!r_csc_valid  || bus.csc_ready) &&
                      (!r_addr_valid || bus.csc_addr_ready);
  assign w_accept   = bus.data_in_valid && w_ready;
  // Any set bit counts as nonzero, so a stray negative value is still encoded.
  assign w_nz       = (bus.data_in != '0);
  assign w_last_row = (r_row_cnt == LAST_ROW);
  assign w_last_col = (r_col_cnt == (r_num_cols - COLS_W'(1)));
  assign w_nz_next  = r_nz_cnt + {{(ADDR_W-1){1'b0}}, w_nz};

  assign bus.data_in_ready  = w_ready;
  assign bus.csc_data       = r_csc_data;
  assign bus.csc_count      = r_csc_count;
  assign bus.csc_valid      = r_csc_valid;
  assign bus.csc_addr       = r_csc_addr;
  assign bus.csc_addr_valid = r_addr_valid;
  assign busy               = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done               = r_done;
  assign overflow           = r_overflow;
  assign o_dbg_state        = r_state;

  // Frame control: state machine plus row/column/nonzero counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_num_cols <= '0;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_nz_cnt   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_num_cols <= (cfg_num_cols == '0) ? COLS_W'(1) : cfg_num_cols;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_nz_cnt   <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept && w_last_row && w_last_col) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!r_csc_valid && !r_addr_valid) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_accept) begin
        r_row_cnt <= w_last_row ? '0 : r_row_cnt + ROW_W'(1);
        r_nz_cnt  <= w_nz_next;
        if (w_last_row) r_col_cnt <= r_col_cnt + COLS_W'(1);
        if (w_nz && (&r_nz_cnt)) r_overflow <= 1'b1;
      end
    end
  end

  // Pair channel: load on a nonzero accept, otherwise release once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csc_data  <= '0;
      r_csc_count <= '0;
      r_csc_valid <= 1'b0;
    end else if (w_accept && w_nz) begin
      r_csc_data  <= bus.data_in;
      r_csc_count <= r_row_cnt;
      r_csc_valid <= 1'b1;
    end else if (bus.csc_ready) begin
      r_csc_valid <= 1'b0;
    end
  end

  // Address channel: load the running nonzero total at each column end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csc_addr   <= '0;
      r_addr_valid <= 1'b0;
    end else if (w_accept && w_last_row) begin
      r_csc_addr   <= w_nz_next;
      r_addr_valid <= 1'b1;
    end else if (bus.csc_addr_ready) begin
      r_addr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iact_csc_encoder.sv
// Directed bench for iact_csc_encoder: per-scenario tasks plus a negedge
// scoreboard that checks every pair and address transfer against queues.
module tb_iact_csc_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] cfg_num_cols = '0;
  logic       busy, done, overflow;
  logic [1:0] dbg_state;

  iact_csc_encoder_if #(.DATA_W(8), .ROW_W(4), .ADDR_W(7)) ifc ();

  iact_csc_encoder #(
    .DATA_W(8), .COL_LEN(16), .ROW_W(4), .ADDR_W(7), .COLS_W(6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_num_cols (cfg_num_cols),
    .bus          (ifc.slave),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .o_dbg_state  (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  logic [6:0]  addr_q[$];
  logic [7:0]  col_buf [16];
  logic        hold_pend = 1'b0;
  logic [11:0] hold_val = '0;

  // scoreboard: observe transfers and stall stability at the falling edge
  initial begin
    logic [11:0] e;
    logic [6:0]  ea;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          total++;
          if (ifc.csc_valid !== 1'b1 || {ifc.csc_data, ifc.csc_count} !== hold_val) begin
            bad++;
            $display("FAIL pair_hold: got v=%0b %h/%0d want %h/%0d", ifc.csc_valid,
                     ifc.csc_data, ifc.csc_count, hold_val[11:4], hold_val[3:0]);
          end
        end
        if (ifc.csc_valid && ifc.csc_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pair_unexpected: got %h/%0d want none", ifc.csc_data, ifc.csc_count);
          end else begin
            e = exp_q.pop_front();
            if ({ifc.csc_data, ifc.csc_count} !== e) begin
              bad++;
              $display("FAIL pair: got %h/%0d want %h/%0d", ifc.csc_data, ifc.csc_count,
                       e[11:4], e[3:0]);
            end
          end
        end
        if (ifc.csc_addr_valid && ifc.csc_addr_ready) begin
          total++;
          if (addr_q.size() == 0) begin
            bad++;
            $display("FAIL addr_unexpected: got %0d want none", ifc.csc_addr);
          end else begin
            ea = addr_q.pop_front();
            if (ifc.csc_addr !== ea) begin
              bad++;
              $display("FAIL addr: got %0d want %0d", ifc.csc_addr, ea);
            end
          end
        end
        hold_pend = ifc.csc_valid && !ifc.csc_ready;
        hold_val  = {ifc.csc_data, ifc.csc_count};
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [5:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_num_cols = n;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      bad++;
      $display("FAIL start_run: got busy=%0b state=%0d want 1/1", busy, dbg_state);
    end
  endtask

  task automatic drive_elem(input logic [7:0] v);
    int n;
    n = 0;
    ifc.data_in = v;
    ifc.data_in_valid = 1'b1;
    @(negedge clk);
    while (ifc.data_in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ifc.data_in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=%0b want 1", ifc.data_in_ready);
    end
    @(posedge clk); #1;
    ifc.data_in_valid = 1'b0;
  endtask

  task automatic send_rows(input int nrows);
    for (int k = 0; k < nrows; k++) drive_elem(col_buf[k]);
  endtask

  task automatic clear_buf();
    for (int k = 0; k < 16; k++) col_buf[k] = 8'd0;
  endtask

  task automatic fill_dense(input logic [7:0] base);
    for (int k = 0; k < 16; k++) begin
      col_buf[k] = base + 8'(k);
      exp_q.push_back({base + 8'(k), 4'(k)});
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout: got done=%0b want 1", done);
    end else begin
      total++;
      if (busy !== 1'b0 || dbg_state !== 2'd0) begin
        bad++;
        $display("FAIL done_idle: got busy=%0b state=%0d want 0/0", busy, dbg_state);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL done_width: got done=%0b want 0", done);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({ifc.csc_data, ifc.csc_count, ifc.csc_valid, ifc.csc_addr, ifc.csc_addr_valid,
         busy, done, overflow, ifc.data_in_ready, dbg_state} !== '0) begin
      bad++;
      $display("FAIL %s: got data=%h cnt=%0d v=%0b addr=%0d av=%0b busy=%0b done=%0b ovf=%0b rdy=%0b st=%0d want all 0",
               tag, ifc.csc_data, ifc.csc_count, ifc.csc_valid, ifc.csc_addr, ifc.csc_addr_valid,
               busy, done, overflow, ifc.data_in_ready, dbg_state);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    #3;
    check_all_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_dense();
    time t0;
    do_start(6'd1);
    fill_dense(8'd1);
    addr_q.push_back(7'd16);
    t0 = $time;
    send_rows(16);
    total++;
    if ($time - t0 !== 160) begin
      bad++;
      $display("FAIL dense_throughput: got %0t want 160", $time - t0);
    end
    wait_done();
  endtask

  task automatic test_sparse();
    do_start(6'd1);
    clear_buf();
    col_buf[2] = 8'd5;
    col_buf[15] = 8'd9;
    exp_q.push_back({8'd5, 4'd2});
    exp_q.push_back({8'd9, 4'd15});
    addr_q.push_back(7'd2);
    send_rows(16);
    total++;
    if (ifc.csc_valid !== 1'b1 || ifc.csc_count !== 4'd15 ||
        ifc.csc_addr_valid !== 1'b1 || ifc.csc_addr !== 7'd2) begin
      bad++;
      $display("FAIL sparse_same_cycle: got v=%0b cnt=%0d av=%0b addr=%0d want 1/15/1/2",
               ifc.csc_valid, ifc.csc_count, ifc.csc_addr_valid, ifc.csc_addr);
    end
    wait_done();
  endtask

  task automatic test_zero_col();
    do_start(6'd3);
    clear_buf();
    col_buf[0] = 8'd10; col_buf[1] = 8'd20; col_buf[2] = 8'd30; col_buf[3] = 8'd40;
    exp_q.push_back({8'd10, 4'd0}); exp_q.push_back({8'd20, 4'd1});
    exp_q.push_back({8'd30, 4'd2}); exp_q.push_back({8'd40, 4'd3});
    addr_q.push_back(7'd4);
    send_rows(16);
    clear_buf();
    addr_q.push_back(7'd4);
    send_rows(16);
    col_buf[5] = 8'd7; col_buf[9] = 8'd8; col_buf[15] = 8'h80;
    exp_q.push_back({8'd7, 4'd5}); exp_q.push_back({8'd8, 4'd9});
    exp_q.push_back({8'h80, 4'd15});
    addr_q.push_back(7'd7);
    send_rows(16);
    wait_done();
  endtask

  task automatic test_backpressure();
    do_start(6'd1);
    fill_dense(8'd33);
    addr_q.push_back(7'd16);
    fork
      send_rows(16);
      begin
        repeat (4) @(posedge clk);
        #1 ifc.csc_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (ifc.data_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready: got %0b want 0", ifc.data_in_ready);
          end
        end
        @(posedge clk); #1;
        ifc.csc_ready = 1'b1;
      end
    join
    wait_done();
  endtask

  task automatic test_overflow();
    do_start(6'd8);
    for (int c = 0; c < 8; c++) begin
      fill_dense(8'd1);
      addr_q.push_back(7'((16 * (c + 1)) % 128));
      send_rows(16);
    end
    wait_done();
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got %0b want 1", overflow);
    end
  endtask

  task automatic test_restart_zero_cfg();
    do_start(6'd0);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: got %0b want 0", overflow);
    end
    clear_buf();
    col_buf[0] = 8'd3;
    exp_q.push_back({8'd3, 4'd0});
    addr_q.push_back(7'd1);
    send_rows(16);
    wait_done();
  endtask

  task automatic test_async_reset();
    do_start(6'd2);
    fill_dense(8'd1);
    addr_q.push_back(7'd16);
    send_rows(16);
    for (int k = 0; k < 8; k++) begin
      col_buf[k] = 8'd50 + 8'(k);
      exp_q.push_back({8'd50 + 8'(k), 4'(k)});
    end
    send_rows(8);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    total++;
    if (addr_q.size() != 0) begin
      bad++;
      $display("FAIL addr_left_before_reset: got %0d want 0", addr_q.size());
    end
    addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_start(6'd1);
    clear_buf();
    col_buf[0] = 8'd11;
    col_buf[7] = 8'd22;
    exp_q.push_back({8'd11, 4'd0});
    exp_q.push_back({8'd22, 4'd7});
    addr_q.push_back(7'd2);
    send_rows(16);
    wait_done();
  endtask

  initial begin
    ifc.data_in = '0;
    ifc.data_in_valid = 1'b0;
    ifc.csc_ready = 1'b1;
    ifc.csc_addr_ready = 1'b1;
    test_reset();
    test_dense();
    test_sparse();
    test_zero_col();
    test_backpressure();
    test_overflow();
    test_restart_zero_cfg();
    test_async_reset();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got pairs=%0d addrs=%0d want 0/0", exp_q.size(), addr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
